pipelined_segmented_adder: RTL and testbench
============================================

Name: pipelined_segmented_adder

Overview:
- Parametrised pipelined adder/subtractor for the arithmetic benchmark set; successor to the fixed-width registered adder.
- Splits a WIDTH-bit add into SEG_WIDTH-bit carry segments, one segment per pipeline stage, and carries the unused operand bits forward in skew registers.
- Adds a valid/ready handshake with backpressure, a subtract mode, carry-in, carry-out and signed overflow.
- Targets long adders where one-cycle carry chains limit Fmax.

Parameters:
- WIDTH, 80, operand width in bits (>=2).
- SEG_WIDTH, 20, bits resolved per pipeline stage (1..WIDTH).
- NUM_SEG, derived = ceil(WIDTH/SEG_WIDTH), not overridable. The last segment holds WIDTH-(NUM_SEG-1)*SEG_WIDTH bits.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands valid.
- in_ready, output, 1, block accepts operands this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- sub, input, 1, 1 = compute a-b, 0 = compute a+b+cin.
- cin, input, 1, carry-in; ignored when sub=1.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- result, output, WIDTH, sum/difference modulo 2^WIDTH.
- cout, output, 1, carry-out. For sub this is the not-borrow bit: 1 iff a>=b unsigned.
- ovf, output, 1, two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - Operand B is b when sub=0, ~b when sub=1.
  - Carry-in is cin when sub=0, 1 when sub=1.
  - {cout,result} = a + B + carry-in.
  - ovf = (a[W-1]==B[W-1]) && (result[W-1]!=a[W-1]).
- Pipeline structure:
  - Stage 0 registers a, B and carry-in on acceptance.
  - Stage k (1..NUM_SEG) adds segment k-1 using the carry registered by stage k-1.
  - Result bits already resolved and operand bits not yet used travel with each stage.
- Global advance: adv = out_ready | ~out_valid. All stage registers and valid bits load only when adv=1; otherwise they hold.
- Handshake:
  - in_ready = adv (combinational).
  - A transfer occurs on in_valid & in_ready.
  - Bubbles (valid=0 stages) propagate but are not collapsed.
- Latency: exactly NUM_SEG+1 cycles from accept to out_valid when out_ready=1 throughout.
- Throughput: 1 op/cycle while out_ready=1.
- Output stability: while out_valid=1 & out_ready=0, result/cout/ovf/out_valid hold stable. in_ready=0 during this time.
- Ordering: results emerge in acceptance order; none are dropped or duplicated.
- Reset:
  - All valid bits clear to 0; out_valid=0.
  - result=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after reset.
  - Data registers may also clear; they are don't-care while invalid.
  - Reset mid-operation discards all in-flight ops. No output appears for them.
- Boundaries:
  - SEG_WIDTH>=WIDTH degenerates to NUM_SEG=1, latency 2.
  - A non-divisible WIDTH gives a narrow last segment; it must still be correct.
  - Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.

Test Plan:
- Reset, WIDTH=80, SEG_WIDTH=20: assert reset 3 cycles, then release -> out_valid=0, result=0, in_ready=1; no out_valid for 10 idle cycles.
- Carry ripple across all segments: a=2^80-1, b=0, cin=1, sub=0, out_ready=1 -> exactly 5 cycles later out_valid=1, result=0, cout=1, ovf=0.
- Subtract with borrow, then signed overflow:
  - a=5, b=7, sub=1 -> result=2^80-2, cout=0, ovf=0.
  - Next op a=2^79-1, b=1, sub=0 -> result=2^79, ovf=1, on the following cycle.
- Backpressure:
  - Setup: 16 back-to-back random ops, out_ready toggling 1,1,0,1,0,0,1...
  - Expected: results match a reference model, in order, no loss or duplication.
  - Expected: output held stable whenever out_ready=0; in_ready==adv every cycle.
- Reset mid-flight: accept 3 ops, assert reset on cycle 2 after the first accept -> none of the 3 ever produce out_valid; the next op issued after reset completes with latency 5.
- Non-divisible width: WIDTH=17, SEG_WIDTH=8 (NUM_SEG=3), a=0x1FFFF, b=0x00001 -> result=0, cout=1, latency 4. Also run 1000 random add/sub ops against the model.

Source files
------------

// File: rtl/pipelined_segmented_adder.sv
// Pipelined adder/subtractor: one SEG_WIDTH-bit carry segment is resolved per stage,
// with operands and partial sums skewed forward alongside a shared valid/ready handshake.
module pipelined_segmented_adder #(
    parameter int WIDTH     = 80,
    parameter int SEG_WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NUM_SEG = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
    // One spare bit above the padded segments so the carry out of bit WIDTH-1
    // always lands in a real register bit, divisible width or not.
    localparam int PW      = NUM_SEG * SEG_WIDTH + 1;

    logic [PW-1:0]      opa_d [0:NUM_SEG];
    logic [PW-1:0]      opa_q [0:NUM_SEG];
    logic [PW-1:0]      opb_d [0:NUM_SEG];
    logic [PW-1:0]      opb_q [0:NUM_SEG];
    logic [PW-1:0]      sum_d [0:NUM_SEG];
    logic [PW-1:0]      sum_q [0:NUM_SEG];
    logic [NUM_SEG:0]   carry_d, carry_q;
    logic [NUM_SEG:0]   vld_d, vld_q;
    logic [WIDTH-1:0]   b_eff;
    logic [SEG_WIDTH:0] seg;
    logic               adv;

    always_comb begin
        adv   = out_ready | ~vld_q[NUM_SEG];
        seg   = '0;
        b_eff = sub ? ~b : b;

        // stage 0: capture operands with B and carry-in already conditioned for subtract
        vld_d[0]   = in_valid;
        opa_d[0]   = {{(PW-WIDTH){1'b0}}, a};
        opb_d[0]   = {{(PW-WIDTH){1'b0}}, b_eff};
        carry_d[0] = sub | cin;
        sum_d[0]   = '0;

        // stage k: resolve segment k-1 with the carry registered by stage k-1
        for (int k = 1; k <= NUM_SEG; k++) begin
            seg = {1'b0, opa_q[k-1][(k-1)*SEG_WIDTH +: SEG_WIDTH]}
                + {1'b0, opb_q[k-1][(k-1)*SEG_WIDTH +: SEG_WIDTH]}
                + (SEG_WIDTH+1)'(carry_q[k-1]);
            vld_d[k]   = vld_q[k-1];
            opa_d[k]   = opa_q[k-1];
            opb_d[k]   = opb_q[k-1];
            sum_d[k]   = sum_q[k-1];
            sum_d[k][(k-1)*SEG_WIDTH +: SEG_WIDTH] = seg[SEG_WIDTH-1:0];
            carry_d[k] = seg[SEG_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q <= vld_d;
        end
        if (adv) begin
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Outputs are forced to zero while invalid so the data path needs no reset.
    always_comb begin
        in_ready  = adv;
        out_valid = vld_q[NUM_SEG];
        result    = '0;
        cout      = 1'b0;
        ovf       = 1'b0;
        if (out_valid) begin
            result = sum_q[NUM_SEG][WIDTH-1:0];
            cout   = carry_q[NUM_SEG] | sum_q[NUM_SEG][WIDTH];
            ovf    = (opa_q[NUM_SEG][WIDTH-1] == opb_q[NUM_SEG][WIDTH-1])
                   && (sum_q[NUM_SEG][WIDTH-1] != opa_q[NUM_SEG][WIDTH-1]);
        end
    end

endmodule

// File: tb/tb_pipelined_segmented_adder.sv
// Directed and randomised checks of pipelined_segmented_adder at 80/20 and 17/8 geometries.
module tb_pipelined_segmented_adder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        iv1, ir1, sub1, cin1, ov1, or1, cout1, ovf1;
    logic [79:0] a1, b1, res1;
    logic        iv2, ir2, sub2, cin2, ov2, or2, cout2, ovf2;
    logic [16:0] a2, b2, res2;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [79:0] r;
        logic        c;
        logic        o;
    } exp_t;

    pipelined_segmented_adder #(.WIDTH(80), .SEG_WIDTH(20)) dut_w80 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .sub(sub1), .cin(cin1), .out_valid(ov1), .out_ready(or1), .result(res1),
        .cout(cout1), .ovf(ovf1)
    );

    pipelined_segmented_adder #(.WIDTH(17), .SEG_WIDTH(8)) dut_w17 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
        .sub(sub2), .cin(cin2), .out_valid(ov2), .out_ready(or2), .result(res2),
        .cout(cout2), .ovf(ovf2)
    );

    // Wide-integer reference: plain w-bit add with conditioned B and carry-in.
    function automatic exp_t model(int w, logic [79:0] a, logic [79:0] b, logic sub, logic cin);
        logic [80:0] mask, bb, full;
        exp_t e;
        mask   = (81'd1 << w) - 81'd1;
        bb     = sub ? (~{1'b0, b} & mask) : {1'b0, b};
        full   = {1'b0, a} + bb + (sub ? 81'd1 : {80'd0, cin});
        e.r    = full[79:0] & mask[79:0];
        e.c    = full[w];
        e.o    = (a[w-1] == bb[w-1]) && (e.r[w-1] != a[w-1]);
        return e;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        if (ov1 !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %0b want 0", ov1); end
        nvec++;
        if (res1 !== 80'd0 || cout1 !== 1'b0 || ovf1 !== 1'b0) begin
            nerr++; $display("FAIL rst_outputs: result=%h cout=%0b ovf=%0b want 0/0/0", res1, cout1, ovf1);
        end
        nvec++;
        if (ir1 !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %0b want 1", ir1); end
        nvec++;
        if (ov2 !== 1'b0 || ir2 !== 1'b1) begin
            nerr++; $display("FAIL rst_w17: out_valid=%0b in_ready=%0b want 0/1", ov2, ir2);
        end
        nvec++;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
                nerr++; $display("FAIL rst_idle[%0d]: out_valid=%0b/%0b want 0/0", i, ov1, ov2);
            end
            nvec++;
        end
    endtask

    task automatic test_carry_ripple;
        or1 = 1'b1; a1 = {80{1'b1}}; b1 = 80'd0; cin1 = 1'b1; sub1 = 1'b0; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (ov1 !== 1'b0) begin nerr++; $display("FAIL ripple_early[%0d]: out_valid=%0b want 0", i, ov1); end
            nvec++;
            step();
        end
        if (ov1 !== 1'b1 || res1 !== 80'd0 || cout1 !== 1'b1 || ovf1 !== 1'b0) begin
            nerr++; $display("FAIL ripple_result: v=%0b r=%h c=%0b o=%0b want 1/0/1/0", ov1, res1, cout1, ovf1);
        end
        nvec++;
        step();
        if (ov1 !== 1'b0) begin nerr++; $display("FAIL ripple_dup: out_valid=%0b want 0", ov1); end
        nvec++;
    endtask

    task automatic test_sub_ovf;
        or1 = 1'b1;
        a1 = 80'd5; b1 = 80'd7; sub1 = 1'b1; cin1 = 1'b1; iv1 = 1'b1;
        step();
        a1 = 80'h7FFF_FFFF_FFFF_FFFF_FFFF; b1 = 80'd1; sub1 = 1'b0; cin1 = 1'b0;
        step();
        iv1 = 1'b0;
        repeat (3) step();
        if (ov1 !== 1'b1 || res1 !== 80'hFFFF_FFFF_FFFF_FFFF_FFFE || cout1 !== 1'b0 || ovf1 !== 1'b0) begin
            nerr++; $display("FAIL sub_borrow: v=%0b r=%h c=%0b o=%0b want 1/fff..fe/0/0", ov1, res1, cout1, ovf1);
        end
        nvec++;
        step();
        if (ov1 !== 1'b1 || res1 !== 80'h8000_0000_0000_0000_0000 || cout1 !== 1'b0 || ovf1 !== 1'b1) begin
            nerr++; $display("FAIL add_ovf: v=%0b r=%h c=%0b o=%0b want 1/800..0/0/1", ov1, res1, cout1, ovf1);
        end
        nvec++;
        step();
        if (ov1 !== 1'b0) begin nerr++; $display("FAIL sub_ovf_tail: out_valid=%0b want 0", ov1); end
        nvec++;
    endtask

    task automatic test_backpressure;
        exp_t        q[$];
        exp_t        e;
        logic [79:0] oa [16];
        logic [79:0] ob [16];
        logic        os [16];
        logic        oc [16];
        bit          pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        int          issued = 0;
        int          cyc = 0;
        for (int i = 0; i < 16; i++) begin
            oa[i] = {16'($urandom), $urandom, $urandom};
            ob[i] = {16'($urandom), $urandom, $urandom};
            os[i] = 1'($urandom_range(0, 1));
            oc[i] = 1'($urandom_range(0, 1));
        end
        while ((issued < 16 || q.size() > 0) && cyc < 300) begin
            or1 = pat[cyc % 7];
            iv1 = (issued < 16);
            if (issued < 16) begin
                a1 = oa[issued]; b1 = ob[issued]; sub1 = os[issued]; cin1 = oc[issued];
            end
            #1;
            if (ir1 !== (or1 | ~ov1)) begin
                nerr++; $display("FAIL bp_in_ready[%0d]: got %0b want %0b", cyc, ir1, or1 | ~ov1);
            end
            nvec++;
            if (ov1 === 1'b1) begin
                if (q.size() == 0) begin
                    nerr++; $display("FAIL bp_extra[%0d]: out_valid=1 with nothing outstanding", cyc);
                end else begin
                    e = q[0];
                    if (res1 !== e.r || cout1 !== e.c || ovf1 !== e.o) begin
                        nerr++; $display("FAIL bp_data[%0d]: r=%h c=%0b o=%0b want %h/%0b/%0b",
                                         cyc, res1, cout1, ovf1, e.r, e.c, e.o);
                    end
                    if (or1) void'(q.pop_front());
                end
                nvec++;
            end
            if (iv1 && ir1) begin
                q.push_back(model(80, a1, b1, sub1, cin1));
                issued++;
            end
            step();
            cyc++;
        end
        iv1 = 1'b0; or1 = 1'b1;
        if (cyc >= 300) begin nerr++; $display("FAIL bp_timeout: %0d ops outstanding", q.size()); end
        nvec++;
        for (int i = 0; i < 6; i++) begin
            if (ov1 !== 1'b0) begin nerr++; $display("FAIL bp_drain[%0d]: out_valid=%0b want 0", i, ov1); end
            nvec++;
            step();
        end
    endtask

    task automatic test_reset_midflight;
        or1 = 1'b1; sub1 = 1'b0; cin1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a1 = 80'(i + 1); b1 = 80'd10; iv1 = 1'b1;
            step();
        end
        iv1 = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ov1 !== 1'b0) begin nerr++; $display("FAIL flush[%0d]: out_valid=%0b want 0", i, ov1); end
            nvec++;
            step();
        end
        a1 = 80'd100; b1 = 80'd23; iv1 = 1'b1;
        step();
        iv1 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (ov1 !== 1'b0) begin nerr++; $display("FAIL flush_lat[%0d]: out_valid=%0b want 0", i, ov1); end
            nvec++;
            step();
        end
        if (ov1 !== 1'b1 || res1 !== 80'd123 || cout1 !== 1'b0) begin
            nerr++; $display("FAIL flush_after: v=%0b r=%h c=%0b want 1/7b/0", ov1, res1, cout1);
        end
        nvec++;
    endtask

    task automatic test_odd_width;
        exp_t q[$];
        exp_t e;
        int   issued = 0;
        int   cyc = 0;
        or2 = 1'b1; a2 = 17'h1FFFF; b2 = 17'h00001; sub2 = 1'b0; cin2 = 1'b0; iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            if (ov2 !== 1'b0) begin nerr++; $display("FAIL w17_early[%0d]: out_valid=%0b want 0", i, ov2); end
            nvec++;
            step();
        end
        if (ov2 !== 1'b1 || res2 !== 17'd0 || cout2 !== 1'b1 || ovf2 !== 1'b0) begin
            nerr++; $display("FAIL w17_wrap: v=%0b r=%h c=%0b o=%0b want 1/0/1/0", ov2, res2, cout2, ovf2);
        end
        nvec++;
        step();
        while ((issued < 1000 || q.size() > 0) && cyc < 3000) begin
            or2 = ($urandom_range(0, 3) != 0);
            iv2 = (issued < 1000);
            a2 = 17'($urandom); b2 = 17'($urandom);
            sub2 = 1'($urandom_range(0, 1)); cin2 = 1'($urandom_range(0, 1));
            #1;
            if (ov2 === 1'b1) begin
                if (q.size() == 0) begin
                    nerr++; $display("FAIL w17_extra[%0d]: out_valid=1 with nothing outstanding", cyc);
                end else begin
                    e = q[0];
                    if (res2 !== e.r[16:0] || cout2 !== e.c || ovf2 !== e.o) begin
                        nerr++; $display("FAIL w17_data[%0d]: r=%h c=%0b o=%0b want %h/%0b/%0b",
                                         cyc, res2, cout2, ovf2, e.r[16:0], e.c, e.o);
                    end
                    if (or2) void'(q.pop_front());
                end
                nvec++;
            end
            if (iv2 && ir2) begin
                q.push_back(model(17, 80'(a2), 80'(b2), sub2, cin2));
                issued++;
            end
            step();
            cyc++;
        end
        iv2 = 1'b0;
        if (cyc >= 3000) begin nerr++; $display("FAIL w17_timeout: %0d ops outstanding", q.size()); end
        nvec++;
    endtask

    initial begin
        reset = 1'b1;
        iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; sub1 = 1'b0; cin1 = 1'b0;
        iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; sub2 = 1'b0; cin2 = 1'b0;
        test_reset();
        test_carry_ripple();
        test_sub_ovf();
        test_backpressure();
        test_reset_midflight();
        test_odd_width();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
